// File: rtl/svc_rv_retire_mon.sv
// svc_rv_retire_mon
//
// Retirement monitor placed behind an RVFI port. It accepts one retire packet
// per rvfi_valid cycle while running, checks that the order and PC sequences
// are continuous, counts retirements, keeps a small ring of recently retired
// {pc, insn} pairs for debug, and ends the run on a halt, a trap or a watchdog
// timeout.
//
// Ports
//   clk, rst           : single clock, synchronous active-high reset
//   rvfi_valid         : retire strobe
//   rvfi_order         : retire sequence number (64 bit)
//   rvfi_insn          : retired instruction word
//   rvfi_pc_rdata      : PC of the retired instruction
//   rvfi_pc_wdata      : PC of the next instruction
//   rvfi_trap          : retired instruction trapped
//   rvfi_halt          : retired instruction halts the CPU
//   hist_idx           : history read index, 0 = most recent retire
//   hist_pc, hist_insn : selected history entry (0 when hist_idx >= hist_count)
//   hist_count         : valid history entries, saturating at HIST_DEPTH
//   retired            : accepted retire count, wraps modulo 2^32
//   done               : run has ended (halt, trap or timeout)
//   pass               : ended by halt with no order or PC error
//   timeout            : ended by the watchdog
//   trapped            : ended by a trap
//   err_order          : sticky order mismatch flag
//   err_pc             : sticky PC continuity mismatch flag

module svc_rv_retire_mon #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned HIST_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rvfi_valid,
  input  logic [63:0]                   rvfi_order,
  input  logic [31:0]                   rvfi_insn,
  input  logic [XLEN-1:0]               rvfi_pc_rdata,
  input  logic [XLEN-1:0]               rvfi_pc_wdata,
  input  logic                          rvfi_trap,
  input  logic                          rvfi_halt,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
  output logic [XLEN-1:0]               hist_pc,
  output logic [31:0]                   hist_insn,
  output logic [$clog2(HIST_DEPTH):0]   hist_count,
  output logic [31:0]                   retired,
  output logic                          done,
  output logic                          pass,
  output logic                          timeout,
  output logic                          trapped,
  output logic                          err_order,
  output logic                          err_pc
);

  localparam int unsigned IW = $clog2(HIST_DEPTH);
  localparam int unsigned CW = IW + 1;
  // Wide enough to hold TIMEOUT-1 for every legal TIMEOUT >= 1.
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_HALT,
    S_TRAP,
    S_TMO
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     retired_q, retired_d;
  logic [63:0]     exp_order_q, exp_order_d;
  logic [XLEN-1:0] prev_wdata_q, prev_wdata_d;
  logic            has_prev_q, has_prev_d;
  logic            err_order_q, err_order_d;
  logic            err_pc_q, err_pc_d;
  logic [TW-1:0]   idle_q, idle_d;
  logic [IW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   hcount_q, hcount_d;

  logic [XLEN-1:0] ring_pc_q   [HIST_DEPTH];
  logic [31:0]     ring_insn_q [HIST_DEPTH];

  logic            accept;
  logic [IW-1:0]   rd_ptr;

  assign accept = (state_q == S_RUN) && rvfi_valid;

  always_comb begin
    state_d      = state_q;
    retired_d    = retired_q;
    exp_order_d  = exp_order_q;
    prev_wdata_d = prev_wdata_q;
    has_prev_d   = has_prev_q;
    err_order_d  = err_order_q;
    err_pc_d     = err_pc_q;
    idle_d       = idle_q;
    wptr_d       = wptr_q;
    hcount_d     = hcount_q;

    if (state_q == S_RUN) begin
      if (rvfi_valid) begin
        retired_d = retired_q + 32'd1;
        if (rvfi_order != exp_order_q) begin
          err_order_d = 1'b1;
        end
        // Resynchronise on the received order so one gap flags only once.
        exp_order_d = rvfi_order + 64'd1;
        if (has_prev_q && (rvfi_pc_rdata != prev_wdata_q)) begin
          err_pc_d = 1'b1;
        end
        prev_wdata_d = rvfi_pc_wdata;
        has_prev_d   = 1'b1;
        wptr_d       = wptr_q + IW'(1);
        if (hcount_q != CW'(HIST_DEPTH)) begin
          hcount_d = hcount_q + CW'(1);
        end
        idle_d = '0;
        if (rvfi_halt) begin
          state_d = S_HALT;
        end else if (rvfi_trap) begin
          state_d = S_TRAP;
        end
      end else if (idle_q == TW'(TIMEOUT - 1)) begin
        state_d = S_TMO;
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      retired_q    <= '0;
      exp_order_q  <= '0;
      prev_wdata_q <= '0;
      has_prev_q   <= 1'b0;
      err_order_q  <= 1'b0;
      err_pc_q     <= 1'b0;
      idle_q       <= '0;
      wptr_q       <= '0;
      hcount_q     <= '0;
    end else begin
      state_q      <= state_d;
      retired_q    <= retired_d;
      exp_order_q  <= exp_order_d;
      prev_wdata_q <= prev_wdata_d;
      has_prev_q   <= has_prev_d;
      err_order_q  <= err_order_d;
      err_pc_q     <= err_pc_d;
      idle_q       <= idle_d;
      wptr_q       <= wptr_d;
      hcount_q     <= hcount_d;
    end
  end

  // Ring storage is not reset; stale entries are hidden by hcount_q.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      ring_pc_q[wptr_q]   <= rvfi_pc_rdata;
      ring_insn_q[wptr_q] <= rvfi_insn;
    end
  end

  // HIST_DEPTH is a power of two, so IW-bit arithmetic gives the modulo wrap.
  assign rd_ptr = wptr_q - IW'(1) - hist_idx;

  always_comb begin
    hist_pc   = '0;
    hist_insn = '0;
    if ({1'b0, hist_idx} < hcount_q) begin
      hist_pc   = ring_pc_q[rd_ptr];
      hist_insn = ring_insn_q[rd_ptr];
    end
  end

  assign hist_count = hcount_q;
  assign retired    = retired_q;
  assign done       = (state_q != S_RUN);
  assign timeout    = (state_q == S_TMO);
  assign trapped    = (state_q == S_TRAP);
  assign pass       = (state_q == S_HALT) && !err_order_q && !err_pc_q;
  assign err_order  = err_order_q;
  assign err_pc     = err_pc_q;

endmodule

// File: tb/tb_svc_rv_retire_mon.sv
`timescale 1ns/1ps

module tb_svc_rv_retire_mon;

  localparam int unsigned TMO_CYC = 16;
  localparam int unsigned DEPTH   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic [31:0] rvfi_pc_rdata;
  logic [31:0] rvfi_pc_wdata;
  logic        rvfi_trap;
  logic        rvfi_halt;
  logic [2:0]  hist_idx;
  logic [31:0] hist_pc;
  logic [31:0] hist_insn;
  logic [3:0]  hist_count;
  logic [31:0] retired;
  logic        done, pass, timeout, trapped, err_order, err_pc;

  svc_rv_retire_mon #(.XLEN(32), .HIST_DEPTH(DEPTH), .TIMEOUT(TMO_CYC)) dut (
    .clk(clk), .rst(rst), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .hist_idx(hist_idx),
    .hist_pc(hist_pc), .hist_insn(hist_insn), .hist_count(hist_count),
    .retired(retired), .done(done), .pass(pass), .timeout(timeout),
    .trapped(trapped), .err_order(err_order), .err_pc(err_pc)
  );

  always #10 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // run state: 0 running, 1 halted, 2 trapped, 3 timed out
  int          m_state;
  int unsigned m_retired;
  logic [63:0] m_next_order;
  logic        m_seen;
  logic [31:0] m_last_next_pc;
  logic        m_err_o, m_err_p;
  int          m_idle;
  logic [31:0] m_hpc[$];
  logic [31:0] m_hinsn[$];

  task automatic model_update();
    if (rst) begin
      m_state = 0; m_retired = 0; m_next_order = 64'd0; m_seen = 1'b0;
      m_last_next_pc = 32'd0; m_err_o = 1'b0; m_err_p = 1'b0; m_idle = 0;
      m_hpc.delete(); m_hinsn.delete();
    end else if (m_state == 0) begin
      if (rvfi_valid) begin
        m_retired++;
        if (rvfi_order != m_next_order) m_err_o = 1'b1;
        m_next_order = rvfi_order + 64'd1;
        if (m_seen && rvfi_pc_rdata != m_last_next_pc) m_err_p = 1'b1;
        m_seen = 1'b1;
        m_last_next_pc = rvfi_pc_wdata;
        m_hpc.push_front(rvfi_pc_rdata);
        m_hinsn.push_front(rvfi_insn);
        if (m_hpc.size() > DEPTH) begin
          void'(m_hpc.pop_back());
          void'(m_hinsn.pop_back());
        end
        m_idle = 0;
        if (rvfi_halt) m_state = 1;
        else if (rvfi_trap) m_state = 2;
      end else begin
        // This idle cycle is the TIMEOUT-th consecutive one.
        if (m_idle + 1 >= TMO_CYC) m_state = 3;
        else m_idle++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic r, input logic v, input logic [63:0] o,
                       input logic [31:0] pc, input logic [31:0] wd,
                       input logic tr, input logic ha);
    rst = r; rvfi_valid = v; rvfi_order = o; rvfi_pc_rdata = pc;
    rvfi_pc_wdata = wd; rvfi_insn = {pc[23:0], 8'h13}; rvfi_trap = tr; rvfi_halt = ha;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 64'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 64'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    drive_idle();
  endtask

  task automatic check_model(input string tag);
    logic [31:0] epc, ein;
    check({tag, "_retired"}, retired, m_retired);
    check({tag, "_done"}, done, m_state != 0);
    check({tag, "_pass"}, pass, m_state == 1 && !m_err_o && !m_err_p);
    check({tag, "_timeout"}, timeout, m_state == 3);
    check({tag, "_trapped"}, trapped, m_state == 2);
    check({tag, "_err_order"}, err_order, m_err_o);
    check({tag, "_err_pc"}, err_pc, m_err_p);
    check({tag, "_hist_count"}, hist_count, m_hpc.size());
    for (int i = 0; i < DEPTH; i++) begin
      hist_idx = 3'(i);
      #1;
      epc = (i < m_hpc.size()) ? m_hpc[i] : 32'd0;
      ein = (i < m_hinsn.size()) ? m_hinsn[i] : 32'd0;
      check($sformatf("%s_hist_pc%0d", tag, i), hist_pc, epc);
      check($sformatf("%s_hist_insn%0d", tag, i), hist_insn, ein);
    end
    hist_idx = 3'd0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0]  ctl;    // {rst, valid, trap, halt}
    logic [63:0] order;
    logic [31:0] pc;
    logic [31:0] wd;
    logic [31:0] e_ret;
    logic [5:0]  e_flg;  // {done, pass, timeout, trapped, err_order, err_pc}
    logic [3:0]  e_cnt;
    logic [31:0] e_h0;
  } vec_t;

  vec_t tbl[$];

  task automatic add_row(input logic [3:0] ctl, input logic [63:0] o, input logic [31:0] pc,
                         input logic [31:0] wd, input logic [31:0] er, input logic [5:0] ef,
                         input logic [3:0] ec, input logic [31:0] eh);
    vec_t v;
    v.ctl = ctl; v.order = o; v.pc = pc; v.wd = wd;
    v.e_ret = er; v.e_flg = ef; v.e_cnt = ec; v.e_h0 = eh;
    tbl.push_back(v);
  endtask

  logic [63:0] r_ord;
  logic [31:0] r_pc, r_wd;
  logic        r_rst, r_v, r_tr, r_ha;
  int          burst;

  initial begin
    hist_idx = 3'd0;
    drive(1'b1, 1'b0, 64'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // sequential run ending in halt, then an ignored packet
    add_row(4'b1000, 64'd0, 32'h0,   32'h0,   32'd0, 6'b000000, 4'd0, 32'h0);
    add_row(4'b0100, 64'd0, 32'h0,   32'h4,   32'd1, 6'b000000, 4'd1, 32'h0);
    add_row(4'b0100, 64'd1, 32'h4,   32'h8,   32'd2, 6'b000000, 4'd2, 32'h4);
    add_row(4'b0100, 64'd2, 32'h8,   32'hC,   32'd3, 6'b000000, 4'd3, 32'h8);
    add_row(4'b0100, 64'd3, 32'hC,   32'h10,  32'd4, 6'b000000, 4'd4, 32'hC);
    add_row(4'b0101, 64'd4, 32'h10,  32'h14,  32'd5, 6'b110000, 4'd5, 32'h10);
    add_row(4'b0100, 64'd5, 32'h14,  32'h18,  32'd5, 6'b110000, 4'd5, 32'h10);
    // order gap, then halt: sticky error blocks pass
    add_row(4'b1000, 64'd0, 32'h0,   32'h0,   32'd0, 6'b000000, 4'd0, 32'h0);
    add_row(4'b0100, 64'd0, 32'h0,   32'h4,   32'd1, 6'b000000, 4'd1, 32'h0);
    add_row(4'b0100, 64'd2, 32'h4,   32'h8,   32'd2, 6'b000010, 4'd2, 32'h4);
    add_row(4'b0101, 64'd3, 32'h8,   32'hC,   32'd3, 6'b100010, 4'd3, 32'h8);
    // jump target mismatch
    add_row(4'b1000, 64'd0, 32'h0,   32'h0,   32'd0, 6'b000000, 4'd0, 32'h0);
    add_row(4'b0100, 64'd0, 32'h0,   32'hFFC, 32'd1, 6'b000000, 4'd1, 32'h0);
    add_row(4'b0100, 64'd1, 32'h8,   32'hC,   32'd2, 6'b000001, 4'd2, 32'h8);
    // jump target honoured
    add_row(4'b1000, 64'd0, 32'h0,   32'h0,   32'd0, 6'b000000, 4'd0, 32'h0);
    add_row(4'b0100, 64'd0, 32'h0,   32'hFFC, 32'd1, 6'b000000, 4'd1, 32'h0);
    add_row(4'b0100, 64'd1, 32'hFFC, 32'h1000, 32'd2, 6'b000000, 4'd2, 32'hFFC);
    add_row(4'b0000, 64'd0, 32'h0,   32'h0,   32'd2, 6'b000000, 4'd2, 32'hFFC);

    foreach (tbl[i]) begin
      drive(tbl[i].ctl[3], tbl[i].ctl[2], tbl[i].order, tbl[i].pc, tbl[i].wd,
            tbl[i].ctl[1], tbl[i].ctl[0]);
      tick();
      check($sformatf("tbl%0d_retired", i), retired, tbl[i].e_ret);
      check($sformatf("tbl%0d_done", i), done, tbl[i].e_flg[5]);
      check($sformatf("tbl%0d_pass", i), pass, tbl[i].e_flg[4]);
      check($sformatf("tbl%0d_timeout", i), timeout, tbl[i].e_flg[3]);
      check($sformatf("tbl%0d_trapped", i), trapped, tbl[i].e_flg[2]);
      check($sformatf("tbl%0d_err_order", i), err_order, tbl[i].e_flg[1]);
      check($sformatf("tbl%0d_err_pc", i), err_pc, tbl[i].e_flg[0]);
      check($sformatf("tbl%0d_hist_count", i), hist_count, tbl[i].e_cnt);
      check($sformatf("tbl%0d_hist_pc0", i), hist_pc, tbl[i].e_h0);
    end

    // watchdog fires on the 16th idle edge
    do_reset();
    for (int k = 1; k < TMO_CYC; k++) begin
      tick();
      check($sformatf("tmo_early%0d", k), timeout, 1'b0);
    end
    tick();
    check("tmo_timeout", timeout, 1'b1);
    check("tmo_done", done, 1'b1);
    check("tmo_pass", pass, 1'b0);
    check("tmo_trapped", trapped, 1'b0);

    // packet on the last idle cycle wins over the watchdog
    do_reset();
    for (int k = 1; k < TMO_CYC; k++) tick();
    drive(1'b0, 1'b1, 64'd0, 32'h0, 32'h4, 1'b0, 1'b0);
    tick();
    drive_idle();
    check("tmo_race_timeout", timeout, 1'b0);
    check("tmo_race_done", done, 1'b0);
    check("tmo_race_retired", retired, 32'd1);
    for (int k = 1; k < TMO_CYC; k++) tick();
    check("tmo_race_still_run", timeout, 1'b0);
    tick();
    check("tmo_race_late_timeout", timeout, 1'b1);

    // history wrap and trap termination
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, 1'b1, 64'(i), 32'(4 * i), 32'(4 * i + 4), i == 10, 1'b0);
      tick();
    end
    check("wrap_hist_count", hist_count, 4'd8);
    check("wrap_trapped", trapped, 1'b1);
    check("wrap_retired", retired, 32'd11);
    hist_idx = 3'd7; #1;
    check("wrap_hist_pc7", hist_pc, 32'hC);
    hist_idx = 3'd0; #1;
    check("wrap_hist_pc0", hist_pc, 32'h28);
    drive(1'b0, 1'b1, 64'd11, 32'h2C, 32'h30, 1'b0, 1'b0);
    tick();
    drive_idle();
    check("trap_ignore_retired", retired, 32'd11);
    check("trap_ignore_hist_pc0", hist_pc, 32'h28);
    check("trap_ignore_count", hist_count, 4'd8);

    // reset mid-run, packet on the reset cycle discarded
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 64'(i), 32'(4 * i), 32'(4 * i + 4), 1'b0, 1'b0);
      tick();
    end
    check("mid_retired3", retired, 32'd3);
    drive(1'b1, 1'b1, 64'd3, 32'hC, 32'h10, 1'b0, 1'b0);
    tick();
    check("mid_rst_retired", retired, 32'd0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_pass", pass, 1'b0);
    check("mid_rst_timeout", timeout, 1'b0);
    check("mid_rst_trapped", trapped, 1'b0);
    check("mid_rst_err_order", err_order, 1'b0);
    check("mid_rst_err_pc", err_pc, 1'b0);
    check("mid_rst_hist_count", hist_count, 4'd0);
    check("mid_rst_hist_pc0", hist_pc, 32'd0);
    check("mid_rst_hist_insn0", hist_insn, 32'd0);
    drive(1'b0, 1'b1, 64'd0, 32'h100, 32'h104, 1'b0, 1'b0);
    tick();
    check("mid_after_err_order", err_order, 1'b0);
    check("mid_after_err_pc", err_pc, 1'b0);
    check("mid_after_retired", retired, 32'd1);
    check_model("mid_after");

    // randomized run against the model
    do_reset();
    check_model("rnd_reset");
    burst = 0;
    for (int c = 0; c < 1500; c++) begin
      r_rst = ($urandom_range(0, 99) == 0) || (m_state != 0 && $urandom_range(0, 7) == 0);
      if (burst > 0) begin
        r_v = 1'b0;
        burst--;
      end else begin
        r_v = ($urandom_range(0, 99) < 70);
        if ($urandom_range(0, 49) == 0) burst = $urandom_range(10, 20);
      end
      r_ord = ($urandom_range(0, 15) == 0) ? m_next_order + 64'($urandom_range(1, 3)) : m_next_order;
      r_pc  = ($urandom_range(0, 15) == 0) ? ($urandom & 32'hFFFC) : m_last_next_pc;
      r_wd  = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFC) : r_pc + 32'd4;
      r_tr  = ($urandom_range(0, 39) == 0);
      r_ha  = ($urandom_range(0, 39) == 0);
      drive(r_rst, r_v, r_ord, r_pc, r_wd, r_tr, r_ha);
      rvfi_insn = $urandom;
      tick();
      check_model($sformatf("rnd%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/svc_rv_retire_mon.md
# svc_rv_retire_mon

Retirement monitor that sits directly downstream of the RV CPU's RVFI port in simulation and formal-replay benches. It consumes one retire packet per `rvfi_valid` cycle and checks order and PC continuity. It counts retirements, keeps a short ring history of retired PC/instruction pairs for debug, and detects end-of-run conditions: halt, trap, or a watchdog timeout. Benches wait on `done` and read the verdict and status instead of polling CPU internals.

## Interface
- `XLEN`, 32: data/PC width.
- `HIST_DEPTH`, 8: history ring entries; power of two, ≥ 2.
- `TIMEOUT`, 1024: idle cycles with no retire before a timeout is declared; ≥ 1.
- Clocking and reset (already decided): one clock; reset is synchronous and active-high.
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `rvfi_valid` in 1: retire strobe.
- `rvfi_order` in 64: retire sequence number.
- `rvfi_insn` in 32: retired instruction word.
- `rvfi_pc_rdata` in XLEN: PC of the retired instruction.
- `rvfi_pc_wdata` in XLEN: next PC.
- `rvfi_trap` in 1: the retired instruction trapped.
- `rvfi_halt` in 1: the retired instruction halts the CPU.
- `hist_idx` in $clog2(HIST_DEPTH): history read index; 0 is the most recent retire.
- `hist_pc` out XLEN: PC of the selected entry.
- `hist_insn` out 32: instruction of the selected entry.
- `hist_count` out $clog2(HIST_DEPTH)+1: number of valid entries; saturates at HIST_DEPTH.
- `retired` out 32: number of accepted retires; wraps modulo 2^32.
- `done` out 1: run ended (halt, trap, or timeout).
- `pass` out 1: `done` with halt, `err_order`=0 and `err_pc`=0.
- `timeout` out 1: run ended by the watchdog.
- `trapped` out 1: run ended by a trap.
- `err_order` out 1: sticky; an `rvfi_order` mismatch occurred.
- `err_pc` out 1: sticky; a PC continuity mismatch occurred.

## Operation
- FSM states: RUN, HALT, TRAP, TMO. HALT, TRAP and TMO are terminal until `rst`.
- In RUN, a cycle with `rvfi_valid`=1 accepts a packet:
  - `retired` increments.
  - The 64-bit expected-order counter is compared to `rvfi_order`; a mismatch sets `err_order`. The expected counter then becomes `rvfi_order`+1, so resync happens after an error.
  - If a previous packet exists, `rvfi_pc_rdata` is compared to the stored previous `rvfi_pc_wdata`; a mismatch sets `err_pc`. The first packet after reset is not PC-checked.
  - {pc_rdata, insn} is written to the ring at the write pointer; the pointer advances and wraps at HIST_DEPTH; `hist_count` increments up to HIST_DEPTH.
  - `rvfi_halt`=1 moves to HALT, taking priority over trap. Otherwise `rvfi_trap`=1 moves to TRAP.
- Packets arriving in a terminal state are ignored: no counters change, no checks run, no history writes.
- Watchdog, RUN only:
  - The idle counter clears on any accepted packet; otherwise it increments.
  - When it reaches TIMEOUT-1 with `rvfi_valid`=0, the FSM enters TMO on that edge.
  - A valid packet on that same cycle wins: the packet is accepted and no timeout occurs.
- History read is combinational from the registered ring: entry = ring[(wptr-1-hist_idx) mod HIST_DEPTH].
  - `hist_idx` ≥ `hist_count` returns 0 on both outputs.
- `done` = state≠RUN; `timeout` = TMO; `trapped` = TRAP; `pass` = HALT && !err_order && !err_pc.
- Width rules: `retired` and the watchdog counter wrap or saturate silently; the order comparison is a full 64-bit compare.

## Timing
- All status outputs are registered and update on the edge that accepts the packet. They are visible the cycle after `rvfi_valid`.
- Reset values while `rst`=1 and after release:
  - state RUN; `retired`=0; expected order 0; idle counter 0.
  - `hist_count`=0; wptr 0; `done`, `pass`, `timeout`, `trapped`, `err_order`, `err_pc` all 0.
  - The "previous packet exists" flag is cleared.
  - Ring contents are don't-care (masked by `hist_count`).
- `rst` asserted mid-run or in a terminal state returns to RUN on the next edge. A packet presented on the reset cycle is discarded.
- Latency from the halting packet to `done`=1 is 1 cycle.
- With no retires after reset, `timeout` rises exactly TIMEOUT cycles after the first post-reset edge.

## Test plan
- Retire 5 sequential packets (order 0..4, pc 0x0,4,8,C,10, with pc_wdata = pc+4); the fifth has `rvfi_halt`=1 → `done`=`pass`=1, `retired`=5, hist_idx 0 returns pc 0x10, hist_count=5.
- Packet order 0, then order 2 → `err_order`=1. Then halt with order 3 → `pass`=0, `err_order` stays 1.
- Jump: pc 0x0 with pc_wdata 0xFFC, then next pc 0x8 → `err_pc`=1. Same jump followed by pc 0xFFC → no error.
- TIMEOUT=16 with no packets → `timeout`=`done`=1 on cycle 16 and `pass`=0. A packet arriving on the final idle cycle prevents the timeout.
- Retire 11 packets with HIST_DEPTH=8 → hist_count=8; hist_idx 7 returns the 4th packet's pc. `rvfi_trap` on packet 11 → `trapped`=1, and packet 12 is ignored (`retired`=11).
- Assert `rst` one cycle mid-run after 3 retires → all outputs 0, and the next packet must carry order 0 without error.
